// File: rtl/instr_exec_unit_if.sv
// Shared instruction/result types and the instr_exec_unit command/read/result bundle.
// slave modport belongs to the execution unit; master to whoever drives it.
package instr_register_pkg;
   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [31:0] operand_t;
   typedef logic        [4:0]  address_t;
   typedef logic signed [63:0] result_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;
endpackage

interface instr_exec_unit_if
   import instr_register_pkg::*;
#(
   parameter int unsigned CNT_W = 6
);
   logic             start;
   address_t         start_addr;
   logic [CNT_W-1:0] num_instr;
   address_t         read_pointer;
   instruction_t     instruction_word;
   logic             res_valid;
   logic             res_ready;
   result_t          result;
   address_t         res_addr;
   logic             div_zero;
   logic             busy;
   logic             done;

   modport master (
      output start, start_addr, num_instr, instruction_word, res_ready,
      input  read_pointer, res_valid, result, res_addr, div_zero, busy, done
   );

   modport slave (
      input  start, start_addr, num_instr, instruction_word, res_ready,
      output read_pointer, res_valid, result, res_addr, div_zero, busy, done
   );
endinterface

// File: rtl/instr_exec_unit.sv
// Walks a range of instr_register entries, executes each opcode and streams tagged results.
// Optional divider: define EXEC_DIV_EN to build DIV/MOD; otherwise they report div_zero.
module instr_exec_unit
   import instr_register_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned CNT_W    = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   instr_exec_unit_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StOut,
      StFinish
   } state_e;

   state_e           state_q;
   address_t         rp_q;
   address_t         res_addr_q;
   logic [CNT_W-1:0] remaining_q;
   result_t          result_q;
   logic             valid_q;
   logic             dz_q;
   logic             busy_q;
   logic             done_q;

   result_t          a_ext;
   result_t          b_ext;
   result_t          alu_res_d;
   logic             alu_dz_d;
   address_t         rp_next;

   always_comb begin
      a_ext     = {{32{bus.instruction_word.op_a[31]}}, bus.instruction_word.op_a};
      b_ext     = {{32{bus.instruction_word.op_b[31]}}, bus.instruction_word.op_b};
      alu_res_d = '0;
      alu_dz_d  = 1'b0;
      case (bus.instruction_word.opc)
         ZERO:  alu_res_d = '0;
         PASSA: alu_res_d = a_ext;
         PASSB: alu_res_d = b_ext;
         ADD:   alu_res_d = a_ext + b_ext;
         SUB:   alu_res_d = a_ext - b_ext;
         MULT:  alu_res_d = a_ext * b_ext;
         DIV, MOD: begin
`ifdef EXEC_DIV_EN
            // 64-bit operands keep -2^31 / -1 representable.
            if (b_ext == '0) begin
               alu_dz_d = 1'b1;
            end else if (bus.instruction_word.opc == DIV) begin
               alu_res_d = a_ext / b_ext;
            end else begin
               alu_res_d = a_ext % b_ext;
            end
`else
            alu_dz_d = 1'b1;
`endif
         end
         default: alu_res_d = '0;
      endcase
   end

   assign rp_next = (rp_q == address_t'(NUM_REGS - 1)) ? '0 : rp_q + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         rp_q        <= '0;
         res_addr_q  <= '0;
         remaining_q <= '0;
         result_q    <= '0;
         valid_q     <= 1'b0;
         dz_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  rp_q        <= bus.start_addr;
                  remaining_q <= bus.num_instr;
                  busy_q      <= 1'b1;
                  if (bus.num_instr == '0) begin
                     state_q <= StFinish;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StFetch;
                  end
               end
            end
            StFetch: state_q <= StExec;
            StExec: begin
               result_q   <= alu_res_d;
               dz_q       <= alu_dz_d;
               res_addr_q <= rp_q;
               valid_q    <= 1'b1;
               state_q    <= StOut;
            end
            StOut: begin
               if (bus.res_ready) begin
                  valid_q     <= 1'b0;
                  remaining_q <= remaining_q - 1'b1;
                  rp_q        <= rp_next;
                  if (remaining_q == CNT_W'(1)) begin
                     state_q <= StFinish;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StFetch;
                  end
               end
            end
            StFinish: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.read_pointer = rp_q;
   assign bus.res_valid    = valid_q;
   assign bus.result       = result_q;
   assign bus.res_addr     = res_addr_q;
   assign bus.div_zero     = dz_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit: runs, wrap, backpressure, DIV/MOD, empty run, mid-run reset.
module tb_instr_exec_unit;
   import instr_register_pkg::*;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;

   instruction_t mem [32];
   result_t      exp_res [$];
   address_t     exp_addr [$];
   logic         exp_dz [$];

   instr_exec_unit_if #(.CNT_W(6)) bus ();

   instr_exec_unit #(
      .NUM_REGS (32),
      .CNT_W    (6)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign bus.instruction_word = mem[bus.read_pointer];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input result_t r, input address_t a, input logic dz);
      exp_res.push_back(r);
      exp_addr.push_back(a);
      exp_dz.push_back(dz);
   endtask

   // Runs a sequence with res_ready high, checking each queued expectation and the 3-clock cadence.
   task automatic run_seq(input address_t sa, input int n);
      int waited;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.start_addr = sa;
      bus.num_instr  = 6'(n);
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < n; k++) begin
         waited = 0;
         while (!bus.res_valid && waited < 12) begin
            @(negedge clk);
            waited++;
         end
         check_eq($sformatf("valid%0d", k), 64'(bus.res_valid), 64'd1);
         check_eq($sformatf("lat%0d", k), 64'(waited), 64'd2);
         check_eq($sformatf("res%0d", k), bus.result, exp_res.pop_front());
         check_eq($sformatf("addr%0d", k), 64'(bus.res_addr), 64'(exp_addr.pop_front()));
         check_eq($sformatf("dz%0d", k), 64'(bus.div_zero), 64'(exp_dz.pop_front()));
         @(negedge clk);
      end
      waited = 0;
      while (!bus.done && waited < 6) begin
         @(negedge clk);
         waited++;
      end
      check_eq("done_pulse", 64'(bus.done), 64'd1);
      @(negedge clk);
      check_eq("done_clear", 64'(bus.done), 64'd0);
      check_eq("busy_clear", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int   waited;
      logic saw_done;
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 32; i++) mem[i] = '0;

      // Reset with inputs forced to non-idle values.
      reset_n        = 1'b0;
      bus.start      = 1'b1;
      bus.start_addr = 5'h1f;
      bus.num_instr  = 6'h3f;
      bus.res_ready  = 1'b1;
      #12;
      check_eq("rst_valid", 64'(bus.res_valid), 64'd0);
      check_eq("rst_result", bus.result, 64'd0);
      check_eq("rst_addr", 64'(bus.res_addr), 64'd0);
      check_eq("rst_rp", 64'(bus.read_pointer), 64'd0);
      check_eq("rst_dz", 64'(bus.div_zero), 64'd0);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      reset_n   = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", 64'(bus.busy), 64'd0);

      // Basic run.
      mem[0] = '{opc: ADD,  op_a: 5,  op_b: 7};
      mem[1] = '{opc: SUB,  op_a: 3,  op_b: 10};
      mem[2] = '{opc: MULT, op_a: -4, op_b: 6};
      push_exp(12, 0, 0);
      push_exp(-7, 1, 0);
      push_exp(-24, 2, 0);
      run_seq(5'd0, 3);

      // Address wrap 30,31,0,1.
      mem[30] = '{opc: PASSA, op_a: -100, op_b: 9};
      mem[31] = '{opc: PASSB, op_a: 1,    op_b: -2};
      push_exp(-100, 30, 0);
      push_exp(-2, 31, 0);
      push_exp(12, 0, 0);
      push_exp(-7, 1, 0);
      run_seq(5'd30, 4);

      // DIV/MOD, full-width MULT, undefined opcode, ZERO.
      mem[10] = '{opc: DIV,  op_a: 7,  op_b: -2};
      mem[11] = '{opc: MOD,  op_a: -7, op_b: 2};
      mem[12] = '{opc: DIV,  op_a: 9,  op_b: 0};
      mem[13] = '{opc: MULT, op_a: 32'sh7fffffff, op_b: 32'sh7fffffff};
      mem[14] = '{opc: opcode_t'(4'hf), op_a: 3, op_b: 4};
      mem[15] = '{opc: DIV,  op_a: 7,  op_b: 2};
      mem[16] = '{opc: ZERO, op_a: 5,  op_b: 5};
`ifdef EXEC_DIV_EN
      push_exp(-3, 10, 0);
      push_exp(-1, 11, 0);
      push_exp(0, 12, 1);
`else
      push_exp(0, 10, 1);
      push_exp(0, 11, 1);
      push_exp(0, 12, 1);
`endif
      push_exp(64'sh3fffffff00000001, 13, 0);
      push_exp(0, 14, 0);
`ifdef EXEC_DIV_EN
      push_exp(3, 15, 0);
`else
      push_exp(0, 15, 1);
`endif
      push_exp(0, 16, 0);
      run_seq(5'd10, 7);

      // Backpressure: outputs hold, pointer frozen, start while busy ignored.
      mem[5] = '{opc: ADD, op_a: 100, op_b: -1};
      bus.res_ready = 1'b0;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.start_addr = 5'd5;
      bus.num_instr  = 6'd1;
      @(negedge clk);
      bus.start = 1'b0;
      waited = 0;
      while (!bus.res_valid && waited < 12) begin
         @(negedge clk);
         waited++;
      end
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("bp_valid%0d", i), 64'(bus.res_valid), 64'd1);
         check_eq($sformatf("bp_res%0d", i), bus.result, 64'd99);
         check_eq($sformatf("bp_addr%0d", i), 64'(bus.res_addr), 64'd5);
         check_eq($sformatf("bp_rp%0d", i), 64'(bus.read_pointer), 64'd5);
         bus.start      = (i == 1);
         bus.start_addr = 5'd20;
         bus.num_instr  = 6'd5;
         @(negedge clk);
      end
      bus.start     = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_drop", 64'(bus.res_valid), 64'd0);
      check_eq("bp_adv", 64'(bus.read_pointer), 64'd6);
      check_eq("bp_done", 64'(bus.done), 64'd1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check_eq("bp_noqueue_busy", 64'(bus.busy), 64'd0);
      check_eq("bp_noqueue_valid", 64'(bus.res_valid), 64'd0);

      // Empty run.
      bus.start      = 1'b1;
      bus.start_addr = 5'd3;
      bus.num_instr  = 6'd0;
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("zero_done", 64'(bus.done), 64'd1);
      check_eq("zero_valid", 64'(bus.res_valid), 64'd0);
      @(negedge clk);
      check_eq("zero_done_clr", 64'(bus.done), 64'd0);
      check_eq("zero_busy", 64'(bus.busy), 64'd0);

      // Reset while waiting in OUT abandons the run.
      bus.res_ready  = 1'b0;
      bus.start      = 1'b1;
      bus.start_addr = 5'd0;
      bus.num_instr  = 6'd3;
      @(negedge clk);
      bus.start = 1'b0;
      waited = 0;
      while (!bus.res_valid && waited < 12) begin
         @(negedge clk);
         waited++;
      end
      check_eq("mr_in_out", 64'(bus.res_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      check_eq("mr_valid", 64'(bus.res_valid), 64'd0);
      check_eq("mr_busy", 64'(bus.busy), 64'd0);
      check_eq("mr_rp", 64'(bus.read_pointer), 64'd0);
      check_eq("mr_result", bus.result, 64'd0);
      @(negedge clk);
      reset_n       = 1'b1;
      bus.res_ready = 1'b1;
      saw_done      = bus.done;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         saw_done = saw_done | bus.done;
      end
      check_eq("mr_no_done", 64'(saw_done), 64'd0);
      check_eq("mr_idle", 64'(bus.busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
